// File: rtl/countdown_ctrl_if.sv
// Signal bundle between the countdown controller, the button one-pulse
// logic and the BCD down-counter / display path.
interface countdown_ctrl_if;
    logic       start_pulse;
    logic       set_pulse;
    logic       inc_pulse;
    logic       sel_pulse;
    logic       cnt_zero;
    logic       cnt_load;
    logic       cnt_en;
    logic [3:0] preset_d1;
    logic [3:0] preset_d0;
    logic [2:0] state;
    logic       sel_digit;
    logic       alarm;

    // Controller side.
    modport slave (
        input  start_pulse,
        input  set_pulse,
        input  inc_pulse,
        input  sel_pulse,
        input  cnt_zero,
        output cnt_load,
        output cnt_en,
        output preset_d1,
        output preset_d0,
        output state,
        output sel_digit,
        output alarm
    );

    // Button / counter side.
    modport master (
        output start_pulse,
        output set_pulse,
        output inc_pulse,
        output sel_pulse,
        output cnt_zero,
        input  cnt_load,
        input  cnt_en,
        input  preset_d1,
        input  preset_d0,
        input  state,
        input  sel_digit,
        input  alarm
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Sequencing FSM for the 2-digit BCD stopwatch down-counter.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | counter holds the preset, waiting for start or set
//   SET   | editing preset digits (sel toggles digit, inc bumps it)
//   RUN   | prescaler running, cnt_en issued once per tick
//   PAUSE | prescaler frozen mid-period, counter holds its value
//   DONE  | counter reached 00, alarm blinks at the tick rate
//
// Pulse priority inside one cycle: set > start > sel > inc; the losers
// are dropped. Every output comes straight from a flop.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter logic [3:0]  PRESET_D1 = 4'd3,
    parameter logic [3:0]  PRESET_D0 = 4'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    countdown_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    d1_q, d1_d;
    logic [3:0]    d0_q, d0_d;
    logic          sel_q, sel_d;
    logic          load_q, load_d;
    logic          en_q, en_d;
    logic          alarm_q, alarm_d;
    logic          init_q;

    logic          tick;
    logic [PW-1:0] presc_nxt;

    // BCD increment with 9 -> 0 wrap; anything out of range also folds to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    assign tick      = (presc_q == PRESC_LAST);
    assign presc_nxt = tick ? '0 : presc_q + 1'b1;

    // Flag that forces one cnt_load right after reset so the counter starts from the preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            d1_q    <= PRESET_D1;
            d0_q    <= PRESET_D0;
            sel_q   <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            en_q    <= en_d;
            alarm_q <= alarm_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        sel_d   = sel_q;
        load_d  = init_q;
        en_d    = 1'b0;
        alarm_d = alarm_q;

        // The prescaler only advances while counting or blinking; a RUN cycle
        // that leaves for PAUSE still advances, and PAUSE then freezes it.
        if (state_q == S_RUN || state_q == S_DONE) begin
            presc_d = presc_nxt;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.set_pulse) begin
                    state_d = S_SET;
                    sel_d   = 1'b0;
                end else if (bus.start_pulse && !bus.cnt_zero) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end

            S_SET: begin
                if (bus.set_pulse) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (bus.start_pulse) begin
                    // Start has no meaning while editing, but it still masks sel/inc.
                    state_d = S_SET;
                end else if (bus.sel_pulse) begin
                    sel_d = ~sel_q;
                end else if (bus.inc_pulse) begin
                    if (sel_q) begin
                        d1_d = bcd_inc(d1_q);
                    end else begin
                        d0_d = bcd_inc(d0_q);
                    end
                end
            end

            S_RUN: begin
                if (bus.cnt_zero) begin
                    state_d = S_DONE;
                    alarm_d = 1'b1;
                end else if (bus.set_pulse) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (bus.start_pulse) begin
                    // A tick landing on the pause press is discarded.
                    state_d = S_PAUSE;
                end else if (tick) begin
                    en_d = 1'b1;
                end
            end

            S_PAUSE: begin
                if (bus.set_pulse) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (bus.start_pulse) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                if (bus.set_pulse || bus.start_pulse) begin
                    state_d = S_IDLE;
                    alarm_d = 1'b0;
                    load_d  = 1'b1;
                end else if (tick) begin
                    alarm_d = ~alarm_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                alarm_d = 1'b0;
            end
        endcase
    end

    assign bus.state     = state_q;
    assign bus.preset_d1 = d1_q;
    assign bus.preset_d0 = d0_q;
    assign bus.sel_digit = sel_q;
    assign bus.cnt_load  = load_q;
    assign bus.cnt_en    = en_q;
    assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with a behavioural BCD down-counter attached.
// Stimulus queues the expected strobes and per-cycle signal values; a
// monitor on the falling edge pops and compares them.
module tb_countdown_ctrl;
    localparam int TICK_DIV = 4;

    localparam int SIG_STATE = 0;
    localparam int SIG_ALARM = 1;
    localparam int SIG_D1    = 2;
    localparam int SIG_D0    = 3;
    localparam int SIG_SEL   = 4;
    localparam int SIG_EN    = 5;
    localparam int SIG_LOAD  = 6;

    typedef struct {
        bit is_load;
        int cyc;
    } strobe_t;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    countdown_ctrl_if bus();

    countdown_ctrl #(
        .TICK_DIV (TICK_DIV),
        .PRESET_D1(4'd3),
        .PRESET_D0(4'd0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    int      cnt_val = 0;
    logic    zero_ovr = 1'b0;
    strobe_t strobe_q[$];
    snap_t   snap_q[$];
    strobe_t mon_e;
    int      mon_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural down-counter: load preset or decrement once per cnt_en.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.cnt_load) begin
                cnt_val <= int'(bus.preset_d1) * 10 + int'(bus.preset_d0);
            end else if (bus.cnt_en && cnt_val > 0) begin
                cnt_val <= cnt_val - 1;
            end
        end
    end

    assign bus.cnt_zero = (cnt_val == 0) || zero_ovr;

    function automatic string sig_name(input int s);
        case (s)
            SIG_STATE: return "state";
            SIG_ALARM: return "alarm";
            SIG_D1:    return "preset_d1";
            SIG_D0:    return "preset_d0";
            SIG_SEL:   return "sel_digit";
            SIG_EN:    return "cnt_en";
            SIG_LOAD:  return "cnt_load";
            default:   return "unknown";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            SIG_STATE: return int'(bus.state);
            SIG_ALARM: return int'(bus.alarm);
            SIG_D1:    return int'(bus.preset_d1);
            SIG_D0:    return int'(bus.preset_d0);
            SIG_SEL:   return int'(bus.sel_digit);
            SIG_EN:    return int'(bus.cnt_en);
            SIG_LOAD:  return int'(bus.cnt_load);
            default:   return -1;
        endcase
    endfunction

    // Monitor: strobes are consumed in order, snapshots matched by cycle.
    always @(negedge clk) begin
        if (bus.cnt_load && bus.cnt_en) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_overlap cycle %0d: cnt_load=1 cnt_en=1, required at most one high", cyc);
        end
        if (bus.cnt_load || bus.cnt_en) begin
            n_checks++;
            if (strobe_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe cycle %0d: cnt_load=%0b cnt_en=%0b, required none",
                         cyc, bus.cnt_load, bus.cnt_en);
            end else begin
                mon_e = strobe_q.pop_front();
                if (mon_e.is_load != bus.cnt_load || mon_e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL strobe cycle %0d load=%0b: required %s at cycle %0d",
                             cyc, bus.cnt_load, mon_e.is_load ? "cnt_load" : "cnt_en", mon_e.cyc);
                end
            end
        end
        for (int i = snap_q.size() - 1; i >= 0; i--) begin
            if (snap_q[i].cyc == cyc) begin
                n_checks++;
                mon_v = sig_val(snap_q[i].sig);
                if (mon_v != snap_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %0d, required %0d",
                             sig_name(snap_q[i].sig), cyc, mon_v, snap_q[i].val);
                end
                snap_q.delete(i);
            end else if (snap_q[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_%s: expectation for cycle %0d never sampled",
                         sig_name(snap_q[i].sig), snap_q[i].cyc);
                snap_q.delete(i);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.start_pulse = 1'b0;
        bus.set_pulse   = 1'b0;
        bus.inc_pulse   = 1'b0;
        bus.sel_pulse   = 1'b0;
    endtask

    task automatic exp_snap(input int off, input int sig, input int val);
        snap_q.push_back('{cyc + off, sig, val});
    endtask

    task automatic exp_strobe(input int off, input bit ld);
        strobe_q.push_back('{ld, cyc + off});
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start_pulse = 1'b0;
        bus.set_pulse   = 1'b0;
        bus.inc_pulse   = 1'b0;
        bus.sel_pulse   = 1'b0;

        // Reset values, then a single cnt_load after release.
        next_cycle();
        exp_snap(0, SIG_STATE, 0);
        exp_snap(0, SIG_D1, 3);
        exp_snap(0, SIG_D0, 0);
        exp_snap(0, SIG_SEL, 0);
        exp_snap(0, SIG_ALARM, 0);
        exp_snap(0, SIG_LOAD, 0);
        exp_snap(0, SIG_EN, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        exp_snap(0, SIG_LOAD, 0);
        exp_strobe(1, 1'b1);
        exp_snap(2, SIG_LOAD, 0);
        repeat (3) next_cycle();

        // Preset edit: units 0->2, tens 3->...->9->0->1.
        bus.set_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 1);
        exp_snap(1, SIG_SEL, 0);
        next_cycle();
        repeat (2) begin
            bus.inc_pulse = 1'b1;
            next_cycle();
        end
        exp_snap(0, SIG_D0, 2);
        bus.sel_pulse = 1'b1;
        exp_snap(1, SIG_SEL, 1);
        exp_snap(7, SIG_D1, 9);
        exp_snap(8, SIG_D1, 0);
        exp_snap(9, SIG_D1, 1);
        next_cycle();
        repeat (8) begin
            bus.inc_pulse = 1'b1;
            next_cycle();
        end
        exp_snap(0, SIG_STATE, 1);
        bus.set_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 0);
        exp_strobe(1, 1'b1);
        exp_snap(1, SIG_D1, 1);
        exp_snap(1, SIG_D0, 2);
        next_cycle();
        repeat (3) next_cycle();

        // Preset 02 for the countdown runs (tens 1 -> 0 in nine steps).
        bus.set_pulse = 1'b1;
        next_cycle();
        bus.sel_pulse = 1'b1;
        next_cycle();
        repeat (9) begin
            bus.inc_pulse = 1'b1;
            next_cycle();
        end
        bus.set_pulse = 1'b1;
        exp_strobe(1, 1'b1);
        exp_snap(1, SIG_D1, 0);
        exp_snap(1, SIG_D0, 2);
        next_cycle();
        repeat (3) next_cycle();

        // Countdown 02 -> 00 -> DONE with blinking alarm, then acknowledge.
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 2);
        exp_strobe(5, 1'b0);
        exp_strobe(9, 1'b0);
        exp_snap(10, SIG_STATE, 2);
        exp_snap(11, SIG_STATE, 4);
        exp_snap(11, SIG_ALARM, 1);
        exp_snap(12, SIG_ALARM, 1);
        exp_snap(13, SIG_ALARM, 0);
        exp_snap(16, SIG_ALARM, 0);
        exp_snap(17, SIG_ALARM, 1);
        exp_snap(20, SIG_ALARM, 1);
        exp_snap(21, SIG_ALARM, 0);
        exp_strobe(23, 1'b1);
        exp_snap(23, SIG_STATE, 0);
        exp_snap(23, SIG_ALARM, 0);
        next_cycle();
        repeat (21) next_cycle();
        bus.start_pulse = 1'b1;
        next_cycle();
        repeat (3) next_cycle();

        // Pause mid-period, resume keeps the partial tick, then abort from RUN.
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 2);
        next_cycle();
        next_cycle();
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 3);
        exp_snap(20, SIG_STATE, 3);
        exp_snap(22, SIG_STATE, 2);
        exp_strobe(24, 1'b0);
        exp_strobe(26, 1'b1);
        exp_snap(26, SIG_STATE, 0);
        next_cycle();
        repeat (20) next_cycle();
        bus.start_pulse = 1'b1;
        next_cycle();
        repeat (3) next_cycle();
        bus.set_pulse = 1'b1;
        next_cycle();
        repeat (3) next_cycle();

        // Start on a tick cycle drops the tick; then abort from PAUSE.
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 2);
        next_cycle();
        repeat (3) next_cycle();
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 3);
        exp_snap(1, SIG_EN, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        bus.set_pulse = 1'b1;
        exp_strobe(1, 1'b1);
        exp_snap(1, SIG_STATE, 0);
        next_cycle();
        repeat (3) next_cycle();

        // set and start together in IDLE: set wins.
        bus.set_pulse   = 1'b1;
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 1);
        exp_snap(1, SIG_SEL, 0);
        next_cycle();
        bus.set_pulse = 1'b1;
        exp_strobe(1, 1'b1);
        exp_snap(1, SIG_STATE, 0);
        next_cycle();
        repeat (2) next_cycle();

        // start with the counter already at zero is ignored.
        zero_ovr = 1'b1;
        next_cycle();
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 0);
        exp_snap(3, SIG_STATE, 0);
        next_cycle();
        repeat (3) next_cycle();
        zero_ovr = 1'b0;
        next_cycle();

        // Asynchronous reset while cnt_en is high clears it at once.
        bus.start_pulse = 1'b1;
        exp_snap(1, SIG_STATE, 2);
        next_cycle();
        repeat (4) next_cycle();
        rst_n = 1'b0;
        exp_snap(0, SIG_EN, 0);
        exp_snap(0, SIG_STATE, 0);
        exp_snap(0, SIG_D1, 3);
        exp_snap(0, SIG_D0, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        exp_strobe(1, 1'b1);
        exp_snap(1, SIG_STATE, 0);
        next_cycle();
        repeat (4) next_cycle();

        n_checks++;
        if (strobe_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes: %0d still pending, required 0", strobe_q.size());
        end
        n_checks++;
        if (snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_snapshots: %0d still pending, required 0", snap_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Control FSM for the 2-digit BCD down-counter/stopwatch datapath.
- Owns the preset value and the run/pause/done sequencing, and generates the count-enable tick from a prescaler.
- Emits load and enable strobes to the down-counter and reads back its zero flag.
- Sits between debounced one-pulse button logic and the counter/LED display path.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per count tick; must be ≥ 4.
- PRESET_D1, 3, reset value of the tens preset digit (BCD).
- PRESET_D0, 0, reset value of the units preset digit (BCD).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_pulse  in  1  one-cycle pulse: start/pause/acknowledge.
- set_pulse  in  1  one-cycle pulse: enter/leave SET, abort.
- inc_pulse  in  1  one-cycle pulse: increment the selected preset digit (SET only).
- sel_pulse  in  1  one-cycle pulse: toggle the selected digit (SET only).
- cnt_zero  in  1  from counter: high when the count is 00.
- cnt_load  out  1  one-cycle strobe: counter loads preset_d1/preset_d0.
- cnt_en  out  1  one-cycle strobe: counter decrements once.
- preset_d1  out  4  tens preset digit, BCD 0..9.
- preset_d0  out  4  units preset digit, BCD 0..9.
- state  out  3  IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4.
- sel_digit  out  1  0 = units selected, 1 = tens selected.
- alarm  out  1  DONE indicator; blinks at the tick rate.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, preset=PRESET_D1/PRESET_D0, sel_digit=0, cnt_en=0, alarm=0, prescaler=0, cnt_load=0.
- After reset: cnt_load is high for exactly the first clock edge after rst_n deasserts (init flag).
- Input priority in one cycle: set_pulse > start_pulse > sel_pulse > inc_pulse. Lower-priority pulses in that cycle are dropped.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1).
  - Cleared on IDLE→RUN.
  - Holds in IDLE, SET and PAUSE.
  - Runs in RUN and DONE.
- IDLE:
  - set_pulse → SET, sel_digit←0.
  - start_pulse with cnt_zero=0 → RUN.
  - start_pulse with cnt_zero=1 → ignored, stay in IDLE.
- SET:
  - sel_pulse toggles sel_digit.
  - inc_pulse increments the selected digit, 9→0 wrap, no carry into the other digit.
  - start_pulse is ignored.
  - set_pulse → IDLE with a cnt_load strobe in the next cycle; the new preset is visible on the same edge.
- RUN:
  - cnt_zero=1 → DONE on the next edge, no cnt_en. This check has highest priority in RUN.
  - Else set_pulse → IDLE plus cnt_load (abort).
  - Else start_pulse → PAUSE. If tick coincides, the tick is dropped and no cnt_en is issued.
  - Else on tick: cnt_en=1 for one cycle (the cycle after the tick cycle).
- PAUSE:
  - start_pulse → RUN, prescaler resumes from its held value, so a partial tick is preserved.
  - set_pulse → IDLE plus cnt_load.
  - cnt_en stays 0.
- DONE:
  - alarm←1 on entry, then toggles on every tick.
  - start_pulse or set_pulse → IDLE, alarm←0, cnt_load strobe (reload preset).
- cnt_en and cnt_load are never high in the same cycle. Each is at most one cycle wide.
- Preset digits change only in SET. They are always valid BCD (never 10..15).
- Asynchronous reset at any time (including mid-RUN or in the same cycle as a pulse) forces all reset values immediately. The post-reset cnt_load then follows.

Test Plan:
(Counter is modelled in the bench; TICK_DIV=4.)
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle, then release.
  - Required: outputs go to reset values asynchronously; preset=3/0, state=0; exactly one cnt_load cycle after release; cnt_en=0.
- Preset edit:
  - Stimulus: set, inc×2 (units 0→2), sel, inc×8 (tens 3→9→0→1), set.
  - Required: preset_d1=1, preset_d0=2; state returns to 0; one cnt_load pulse; no cnt_en throughout.
- Countdown:
  - Stimulus: counter loaded 02; start_pulse at cycle 0.
  - Required: state=2 at cycle 1; cnt_en at cycles 5 and 9; cnt_zero seen at cycle 10; state=4 and alarm=1 at cycle 11; alarm toggles every 4 cycles; start → state=0, alarm=0, cnt_load pulse.
- Pause/resume:
  - Stimulus: start_pulse at cycle 3 of RUN; hold 20 cycles; start again.
  - Required: state=3, no cnt_en while paused; after resume, next cnt_en after the remaining prescaler cycles, not a full TICK_DIV.
- Collisions:
  - start_pulse on a tick cycle in RUN → PAUSE, no cnt_en.
  - set+start in the same cycle in IDLE → SET.
  - start in IDLE with cnt_zero=1 → stays IDLE.
- Abort:
  - Stimulus: set_pulse in RUN and in PAUSE.
  - Required: state=0 and one cnt_load pulse in each case; reset mid-RUN clears cnt_en immediately.
